bcd_counter_disp: RTL and testbench

Parametrised N-digit BCD up/down counter with a built-in tick prescaler and per-digit seven-segment decoding. It replaces switch-driven static digit display on the HEX outputs with a live counter: load, count up or down, wrap, and optional leading-zero blanking. It sits between board inputs (switches and keys, already synchronised upstream) and the HEX displays.

---
 rtl/bcd_counter_disp_pkg.sv | 44 ++++
 rtl/bcd_to_seg7.sv | 16 +
 rtl/bcd_counter_disp.sv | 86 ++++++++
 tb/tb_bcd_counter_disp.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_disp_pkg.sv
// rtl/bcd_counter_disp_pkg.sv - shared BCD limits, seven-segment codes and digit helpers
package bcd_counter_disp_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Active-high {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

  function automatic logic [3:0] bcd_inc(input logic [3:0] d);
    return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] bcd_dec(input logic [3:0] d);
    return (d == 4'd0) ? BCD_MAX : d - 4'd1;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - one BCD digit to seven segments with blanking and polarity select
module bcd_to_seg7 import bcd_counter_disp_pkg::*; (
  input  logic [3:0] bcd,
  input  logic       blank,
  input  logic       act_low,
  output logic [6:0] seg
);

  logic [6:0] seg_hi;

  always_comb begin
    seg_hi = blank ? SEG_BLANK : seg_of(bcd);
    seg    = act_low ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/bcd_counter_disp.sv
// rtl/bcd_counter_disp.sv - prescaled N-digit BCD up/down counter driving HEX displays
module bcd_counter_disp import bcd_counter_disp_pkg::*; #(
  parameter int DIGITS      = 4,
  parameter int TICK_DIV    = 50000000,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  wrap
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]       presc_q, presc_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, bcd_step, load_clamp;
  logic                wrap_q, wrap_d;
  logic                step;
  logic [DIGITS:0]     carry;
  logic [DIGITS:0]     zero_above;

  assign step          = en && (presc_q == PRESC_LAST);
  assign carry[0]      = 1'b1;
  assign zero_above[DIGITS] = 1'b1;

  // carry doubles as borrow when counting down; carry[DIGITS] means the whole count rolls over
  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    logic [3:0] dig;
    logic [3:0] ld;

    assign dig = bcd_q[4*k +: 4];
    assign ld  = load_val[4*k +: 4];
    assign load_clamp[4*k +: 4] = (ld > BCD_MAX) ? BCD_MAX : ld;
    assign carry[k+1] = carry[k] & (up_dn ? (dig == BCD_MAX) : (dig == 4'd0));
    assign bcd_step[4*k +: 4] = !carry[k] ? dig : (up_dn ? bcd_inc(dig) : bcd_dec(dig));
    assign zero_above[k] = zero_above[k+1] & (dig == 4'd0);

    bcd_to_seg7 u_seg (
      .bcd     (dig),
      .blank   ((k != 0) && blank_lz && zero_above[k]),
      .act_low (SEG_ACT_LOW != 0),
      .seg     (hex[7*k +: 7])
    );
  end

  always_comb begin
    presc_d = presc_q;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    if (load) begin
      presc_d = '0;
      bcd_d   = load_clamp;
    end else if (en) begin
      if (step) begin
        presc_d = '0;
        bcd_d   = bcd_step;
        wrap_d  = carry[DIGITS];
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      bcd_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      bcd_q   <= bcd_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bcd  = bcd_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_bcd_counter_disp.sv
// tb/tb_bcd_counter_disp.sv - scoreboard bench for bcd_counter_disp (4 digits, TICK_DIV=4, active-low)
module tb_bcd_counter_disp;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 4;
  localparam int MAXV     = 9999;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        up_dn = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd;
  logic [27:0] hex;
  logic        wrap;

  bcd_counter_disp #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV), .SEG_ACT_LOW(1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .bcd      (bcd),
    .hex      (hex),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] b;
    logic        w;
    logic [27:0] h;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   m_val = 0;
  int   m_presc = 0;
  logic m_wrap = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int r = 0;
    int p = 1;
    for (int k = 0; k < DIGITS; k++) begin
      int d = int'(lv[4*k +: 4]);
      if (d > 9) d = 9;
      r += d * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [27:0] exp_hex(input int v, input logic bl);
    logic [27:0] r;
    int p = 1;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      int d = (v / p) % 10;
      r[7*k +: 7] = (k > 0 && bl && v < p) ? 7'h7F : ~seg_tab[d];
      p *= 10;
    end
    return r;
  endfunction

  // Advances the reference model one clock, queues its prediction, then clocks the DUT
  task automatic advance();
    exp_t e;
    if (!rst_n) begin
      m_val = 0; m_presc = 0; m_wrap = 1'b0;
    end else if (load) begin
      m_val = from_load(load_val); m_presc = 0; m_wrap = 1'b0;
    end else if (en) begin
      m_wrap = 1'b0;
      if (m_presc == TICK_DIV - 1) begin
        m_presc = 0;
        if (up_dn) begin
          if (m_val == MAXV) begin m_val = 0; m_wrap = 1'b1; end
          else m_val++;
        end else begin
          if (m_val == 0) begin m_val = MAXV; m_wrap = 1'b1; end
          else m_val--;
        end
      end else begin
        m_presc++;
      end
    end else begin
      m_wrap = 1'b0;
    end
    e.b = to_bcd(m_val);
    e.w = m_wrap;
    e.h = exp_hex(m_val, blank_lz);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++;
    if ({bcd, wrap} !== {16'h0000, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: bcd=%h wrap=%b expected bcd=0000 wrap=0", bcd, wrap);
    end
    n_vec++;
    if (hex !== {4{7'h40}}) begin
      n_err++;
      $display("FAIL reset_hex: hex=%h expected %h", hex, {4{7'h40}});
    end
    blank_lz = 1'b1;
    #1;
    n_vec++;
    if (hex !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
      n_err++;
      $display("FAIL reset_hex_blank: hex=%h expected %h", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40});
    end
    blank_lz = 1'b0;
    #5;
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    exp_t e;
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      advance();
      e = sb.pop_front();
      n_vec++;
      if ({bcd, wrap, hex} !== {e.b, e.w, e.h}) begin
        n_err++;
        $display("FAIL count_up cyc %0d: bcd=%h wrap=%b hex=%h expected bcd=%h wrap=%b hex=%h",
                 i, bcd, wrap, hex, e.b, e.w, e.h);
      end
    end
    n_vec++;
    if (bcd !== 16'h0010) begin
      n_err++;
      $display("FAIL count_up_final: bcd=%h expected 0010", bcd);
    end
  endtask

  task automatic test_up_wrap();
    exp_t e;
    int pulses = 0;
    en = 1'b0; load = 1'b1; load_val = 16'h9999;
    advance();
    e = sb.pop_front();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    n_vec++;
    if ({bcd, wrap} !== {e.b, e.w}) begin
      n_err++;
      $display("FAIL up_wrap_load: bcd=%h wrap=%b expected bcd=%h wrap=%b", bcd, wrap, e.b, e.w);
    end
    for (int i = 0; i < 6; i++) begin
      advance();
      e = sb.pop_front();
      if (wrap === 1'b1) pulses++;
      n_vec++;
      if ({bcd, wrap, hex} !== {e.b, e.w, e.h}) begin
        n_err++;
        $display("FAIL up_wrap cyc %0d: bcd=%h wrap=%b hex=%h expected bcd=%h wrap=%b hex=%h",
                 i, bcd, wrap, hex, e.b, e.w, e.h);
      end
      if (i == 3) begin
        n_vec++;
        if ({bcd, wrap} !== {16'h0000, 1'b1}) begin
          n_err++;
          $display("FAIL up_wrap_edge: bcd=%h wrap=%b expected bcd=0000 wrap=1", bcd, wrap);
        end
      end
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++;
      $display("FAIL up_wrap_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_down();
    exp_t e;
    logic [15:0] start [2] = '{16'h0100, 16'h0000};
    logic [16:0] final_v [2] = '{{16'h0099, 1'b0}, {16'h9999, 1'b1}};
    for (int t = 0; t < 2; t++) begin
      en = 1'b0; load = 1'b1; load_val = start[t];
      advance();
      e = sb.pop_front();
      load = 1'b0; en = 1'b1; up_dn = 1'b0;
      for (int i = 0; i < 4; i++) begin
        advance();
        e = sb.pop_front();
        n_vec++;
        if ({bcd, wrap, hex} !== {e.b, e.w, e.h}) begin
          n_err++;
          $display("FAIL down %0d cyc %0d: bcd=%h wrap=%b hex=%h expected bcd=%h wrap=%b hex=%h",
                   t, i, bcd, wrap, hex, e.b, e.w, e.h);
        end
      end
      n_vec++;
      if ({bcd, wrap} !== final_v[t]) begin
        n_err++;
        $display("FAIL down_final %0d: bcd=%h wrap=%b expected %h", t, bcd, wrap, final_v[t]);
      end
    end
  endtask

  task automatic test_load_priority();
    exp_t e;
    en = 1'b0; load = 1'b1; load_val = 16'h0000;
    advance();
    e = sb.pop_front();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      advance();
      e = sb.pop_front();
    end
    load = 1'b1; load_val = 16'h3C5A;
    advance();
    e = sb.pop_front();
    n_vec++;
    if ({bcd, wrap} !== {16'h3959, 1'b0}) begin
      n_err++;
      $display("FAIL load_clamp: bcd=%h wrap=%b expected bcd=3959 wrap=0", bcd, wrap);
    end
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      advance();
      e = sb.pop_front();
      n_vec++;
      if ({bcd, wrap, hex} !== {e.b, e.w, e.h}) begin
        n_err++;
        $display("FAIL load_presc cyc %0d: bcd=%h wrap=%b hex=%h expected bcd=%h wrap=%b hex=%h",
                 i, bcd, wrap, hex, e.b, e.w, e.h);
      end
    end
  endtask

  task automatic test_pause_blank();
    exp_t e;
    logic [15:0] lv [3]  = '{16'h0007, 16'h0007, 16'h0105};
    logic        bl [3]  = '{1'b1, 1'b0, 1'b1};
    logic [27:0] hx [3]  = '{{7'h7F, 7'h7F, 7'h7F, 7'h78},
                             {7'h40, 7'h40, 7'h40, 7'h78},
                             {7'h7F, 7'h79, 7'h40, 7'h12}};
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      en = (i >= 2 && i < 12) ? 1'b0 : 1'b1;
      advance();
      e = sb.pop_front();
      n_vec++;
      if ({bcd, wrap, hex} !== {e.b, e.w, e.h}) begin
        n_err++;
        $display("FAIL pause cyc %0d: bcd=%h wrap=%b hex=%h expected bcd=%h wrap=%b hex=%h",
                 i, bcd, wrap, hex, e.b, e.w, e.h);
      end
    end
    n_vec++;
    if (bcd !== 16'h3961) begin
      n_err++;
      $display("FAIL pause_resume: bcd=%h expected 3961", bcd);
    end
    en = 1'b0;
    for (int t = 0; t < 3; t++) begin
      load = 1'b1; load_val = lv[t]; blank_lz = bl[t];
      advance();
      e = sb.pop_front();
      n_vec++;
      if (hex !== hx[t] || hex !== e.h) begin
        n_err++;
        $display("FAIL blank %0d: hex=%h expected %h", t, hex, hx[t]);
      end
    end
    load = 1'b0; blank_lz = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    en = 1'b0; load = 1'b1; load_val = 16'h1234;
    advance();
    e = sb.pop_front();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      advance();
      e = sb.pop_front();
    end
    n_vec++;
    if (bcd !== 16'h1234) begin
      n_err++;
      $display("FAIL areset_pre: bcd=%h expected 1234", bcd);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bcd, wrap, hex} !== {16'h0000, 1'b0, {4{7'h40}}}) begin
      n_err++;
      $display("FAIL areset_immediate: bcd=%h wrap=%b hex=%h expected bcd=0000 wrap=0 hex=%h",
               bcd, wrap, hex, {4{7'h40}});
    end
    advance();
    e = sb.pop_front();
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      advance();
      e = sb.pop_front();
      n_vec++;
      if ({bcd, wrap, hex} !== {e.b, e.w, e.h}) begin
        n_err++;
        $display("FAIL areset_release cyc %0d: bcd=%h wrap=%b hex=%h expected bcd=%h wrap=%b hex=%h",
                 i, bcd, wrap, hex, e.b, e.w, e.h);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_up_wrap();
    test_down();
    test_load_priority();
    test_pause_blank();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
